// File: rtl/complement_mode_ctrl.sv
// Key conditioning and mode sequencing for the switch-to-hex complement display.
// Outputs a registered 12-bit pass/one's/two's complement of the switches, plus a change strobe.
module complement_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [9:0]  SW,
    input  logic [1:0]  KEY,
    output logic [1:0]  mode,
    output logic        hold,
    output logic [11:0] result,
    output logic        result_valid
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        PASS = 2'b00,
        ONES = 2'b01,
        TWOS = 2'b10
    } mode_e;

    logic [1:0]         key_s1_q, key_s2_q;
    logic [9:0]         sw_s1_q, sw_s2_q;
    logic [1:0][CW-1:0] cnt_q;
    logic [1:0]         db_q, db_prev_q;
    logic [1:0]         press;
    mode_e              mode_q, mode_d;
    logic               hold_q;
    logic [11:0]        operand_q;
    logic [11:0]        result_q, result_d;
    logic               valid_q;

    // Released keys idle high, so a press is a falling edge of the debounced level.
    assign press = db_prev_q & ~db_q;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            key_s1_q  <= 2'b11;
            key_s2_q  <= 2'b11;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            cnt_q     <= '0;
            db_q      <= 2'b11;
            db_prev_q <= 2'b11;
        end else begin
            key_s1_q  <= KEY;
            key_s2_q  <= key_s1_q;
            sw_s1_q   <= SW;
            sw_s2_q   <= sw_s1_q;
            db_prev_q <= db_q;
            for (int k = 0; k < 2; k++) begin
                if (key_s2_q[k] != db_q[k]) begin
                    if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[k]  <= key_s2_q[k];
                        cnt_q[k] <= '0;
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CW'(1);
                    end
                end else begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press[0]) begin
            case (mode_q)
                PASS:    mode_d = ONES;
                ONES:    mode_d = TWOS;
                TWOS:    mode_d = PASS;
                default: mode_d = PASS;
            endcase
        end else if (mode_q != PASS && mode_q != ONES && mode_q != TWOS) begin
            mode_d = PASS;
        end
    end

    always_comb begin
        result_d = operand_q;
        case (mode_q)
            ONES:    result_d = ~operand_q;
            TWOS:    result_d = ~operand_q + 12'd1;
            default: result_d = operand_q;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            mode_q    <= PASS;
            hold_q    <= 1'b0;
            operand_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            hold_q   <= hold_q ^ press[1];
            // The edge that raises hold still loads, so the frozen value is the last live one.
            if (!hold_q)
                operand_q <= {2'b00, sw_s2_q};
            result_q <= result_d;
            valid_q  <= (result_d != result_q);
        end
    end

    assign mode         = mode_q;
    assign hold         = hold_q;
    assign result       = result_q;
    assign result_valid = valid_q;
endmodule

// File: tb/tb_complement_mode_ctrl.sv
// Scoreboard bench: stimulus pushes expected {mode,result} per strobe; monitor pops on result_valid.
module tb_complement_mode_ctrl;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  SW;
    logic [1:0]  KEY;
    logic [1:0]  mode;
    logic        hold;
    logic [11:0] result;
    logic        result_valid;

    typedef struct packed {
        logic [1:0]  m;
        logic [11:0] r;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    complement_mode_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50(clk), .rst_n(rst_n), .SW(SW), .KEY(KEY),
        .mode(mode), .hold(hold), .result(result), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && result_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got mode=%0d result=%h, required no strobe", mode, result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (mode !== e.m || result !== e.r) begin
                    errors++;
                    $display("FAIL strobe: got mode=%0d result=%h, required mode=%0d result=%h",
                             mode, result, e.m, e.r);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_res(input logic [1:0] m, input logic [11:0] r);
        exp_t e;
        e.m = m;
        e.r = r;
        exp_q.push_back(e);
    endtask

    // Wait a bounded number of cycles for all expected strobes to appear.
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d strobes missing after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic press(input logic [1:0] keys);
        KEY = ~keys;
        cyc(20);
        KEY = 2'b11;
        cyc(10);
    endtask

    task automatic bounce();
        KEY[0] = 1'b0; cyc(3);
        KEY[0] = 1'b1; cyc(2);
        KEY[0] = 1'b0; cyc(3);
    endtask

    initial begin
        rst_n = 1'b0;
        SW    = 10'h2A5;
        KEY   = 2'b11;
        cyc(3);
        chk("reset_result", result, 12'h000);
        chk("reset_valid", result_valid, 0);
        chk("reset_mode", mode, 0);
        chk("reset_hold", hold, 0);

        expect_res(2'd0, 12'h2A5);
        rst_n = 1'b1;
        drain("startup_result", 5);
        cyc(5);

        expect_res(2'd1, 12'hD5A);
        press(2'b01);
        drain("press_ones", 5);
        chk("mode_ones", mode, 1);
        expect_res(2'd2, 12'hD5B);
        press(2'b01);
        drain("press_twos", 5);
        chk("mode_twos", mode, 2);
        expect_res(2'd0, 12'h2A5);
        press(2'b01);
        drain("press_pass", 5);
        chk("mode_pass", mode, 0);

        bounce();
        KEY[0] = 1'b1;
        cyc(20);
        chk("bounce_no_step", mode, 0);

        expect_res(2'd1, 12'hD5A);
        bounce();
        cyc(20);
        KEY[0] = 1'b1;
        cyc(20);
        drain("bounce_then_low", 5);
        chk("bounce_one_step", mode, 1);

        expect_res(2'd2, 12'hD5B);
        press(2'b01);
        drain("to_twos", 5);
        expect_res(2'd2, 12'h000);
        SW = 10'h000; cyc(1);
        drain("twos_zero", 5);
        expect_res(2'd2, 12'hFFF);
        SW = 10'h001; cyc(1);
        drain("twos_one", 5);
        expect_res(2'd2, 12'hC01);
        SW = 10'h3FF; cyc(1);
        drain("twos_3ff", 5);
        expect_res(2'd2, 12'hD5B);
        SW = 10'h2A5; cyc(1);
        drain("twos_2a5", 5);
        expect_res(2'd0, 12'h2A5);
        press(2'b01);
        drain("back_to_pass", 5);

        press(2'b10);
        chk("hold_on", hold, 1);
        SW = 10'h155;
        cyc(10);
        chk("hold_frozen", result, 12'h2A5);
        expect_res(2'd0, 12'h155);
        KEY[1] = 1'b0;
        begin
            int n = 0;
            while (hold !== 1'b0 && n < 30) begin
                cyc(1);
                n++;
            end
        end
        chk("hold_off", hold, 0);
        drain("hold_release", 3);
        KEY[1] = 1'b1;
        cyc(20);

        expect_res(2'd1, 12'hEAA);
        KEY = 2'b00;
        begin
            int n = 0;
            while (mode == 2'd0 && hold == 1'b0 && n < 30) begin
                cyc(1);
                n++;
            end
        end
        chk("both_mode", mode, 1);
        chk("both_hold", hold, 1);
        KEY = 2'b11;
        drain("both_result", 5);
        cyc(20);

        KEY[0] = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        cyc(2);
        chk("midrst_result", result, 12'h000);
        chk("midrst_mode", mode, 0);
        chk("midrst_hold", hold, 0);
        chk("midrst_valid", result_valid, 0);
        expect_res(2'd0, 12'h155);
        expect_res(2'd1, 12'hEAA);
        rst_n = 1'b1;
        cyc(5);
        chk("requalify_mode", mode, 0);
        drain("requalify_press", 10);
        chk("requalify_step", mode, 1);
        KEY[0] = 1'b1;
        cyc(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/complement_mode_ctrl.md
# complement_mode_ctrl

Sequencing controller for the switch-to-hex complement display path. It conditions the raw pushbuttons (synchronize, debounce, press-detect) and runs a mode state machine: KEY[0] steps the transform through pass / one's complement / two's complement, and KEY[1] toggles an operand hold. It registers the 12-bit transformed result and a change strobe. The three 7-segment decoders consume `result[3:0]`, `result[7:4]` and `result[11:8]` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz); must be ≥ 1.
- `CLOCK_50`  in  1: system clock; all logic on its rising edge.
- `rst_n`  in  1: reset; **one clock; reset is synchronous and active-low**.
- `SW`  in  10: raw slide switches, asynchronous.
- `KEY`  in  2: raw pushbuttons, active-low, asynchronous, bouncing. KEY[0] is mode step; KEY[1] is hold toggle.
- `mode`  out  2: 2'b00 PASS, 2'b01 ONES, 2'b10 TWOS.
- `hold`  out  1: 1 = operand frozen.
- `result`  out  12: registered transformed operand.
- `result_valid`  out  1: one-cycle strobe, high in the cycle `result` takes a new, different value.

## Operation
- **Synchronizers:** 2-flop synchronizer on each KEY bit, reset value 1 (released). 2-flop synchronizer on each SW bit, reset value 0.
- **Debounce (per key):**
  - Counter plus debounced level (reset: counter 0, level 1).
  - When the synced value differs from the debounced level, the counter increments.
  - When they are equal, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES have no effect.
- **Press pulse:** one cycle, when the debounced level goes 1→0. Release generates nothing. A held key yields exactly one pulse.
- **Mode FSM:**
  - Transitions on a KEY[0] press: PASS → ONES → TWOS → PASS.
  - Encoding 2'b11 is unreachable; if ever present, the next state is PASS.
- **Hold:** toggles on each KEY[1] press.
- **Both keys pressed in the same cycle:** mode advances and hold toggles in that same cycle.
- **Operand register (12 bits):**
  - When hold=0, it loads {2'b00, SW_sync} every cycle.
  - When hold=1, it keeps its value.
  - Entering hold freezes the value loaded in the cycle before hold rose.
- **Result computation (registered), all modulo 2^12:**
  - PASS: operand.
  - ONES: ~operand.
  - TWOS: ~operand + 1. Operand 0 gives 0x000; there is no carry-out.
- **result_valid:** registered as (next result ≠ current result). It is 0 when the value does not change, including a mode change that leaves the value identical.
- **Reset values:** all outputs and internal state are cleared.
  - mode = PASS, hold = 0, result = 0x000, result_valid = 0.
  - Operand 0, synchronizers as listed above, debounce counters 0, debounced levels 1.
- **Reset mid-operation:** asserting rst_n mid-debounce or mid-hold discards the in-progress count and the held operand. A key still held low after reset must re-qualify for the full DEBOUNCE_CYCLES before it produces a press.

## Timing
- **SW to result:** SW changes before edge t.
  - SW_sync is valid after edge t+1.
  - Operand updates at t+2.
  - result and result_valid update at t+3.
  - Total latency: 3 cycles.
- **KEY to debounced level:** KEY goes low and stays low before edge t. The synced level is low after t+1, and the debounced level falls at edge t+1+DEBOUNCE_CYCLES.
- **Press pulse to outputs:** the pulse is combinational from the debounced edge (debounced 0, previous debounced 1).
  - mode or hold updates on the next edge.
  - The new result (if hold is unaffected) follows on the edge after that.
- **Strobe shape:** result_valid is high for exactly one cycle per change; back-to-back changes give back-to-back strobes.
- **Throughput:** no handshake. Downstream samples `result` continuously.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, SW=0x2A5, keys released → result 0x2A5 at edge 3 after rst_n deasserts, one result_valid strobe, mode 00, hold 0.
- Clean KEY[0] press (low 20 cycles) → mode 01, result 0xD5A with strobe. Second press → mode 10, result 0xD5B. Third press → mode 00, result 0x2A5. Exactly one step per press.
- Bounce on KEY[0]: low 3 cycles, high 2, low 3, then high → no mode change, no strobe. Same pattern followed by a steady low → exactly one step.
- Mode TWOS, SW=0x000 → result 0x000. SW=0x001 → 0xFFF. SW=0x3FF → 0xC01.
- Press KEY[1] (hold=1), change SW 0x2A5 → 0x155 → result stays 0x2A5, no strobe. Press KEY[1] again → result 0x155 within 3 cycles of the hold release, one strobe.
- Both keys pressed in the same cycle while in PASS → mode 01 and hold 1 on the same edge. Assert rst_n low mid-debounce with KEY held → after release of reset, all outputs at reset values. The press is recognized only after a fresh 4-cycle qualification.
